// File: rtl/coalesce.sv
// Writeback reduction stage: passes ordinary lane results through and folds
// multi-beat vdot products into one scalar written back on the last beat.
module coalesce #(
  parameter int unsigned LANES = 4,
  parameter int unsigned W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x2_valid,
  input  logic [15:0]          x2_ins,
  input  logic                 x2_last,
  input  logic [LANES-1:0]     x2_mask,
  input  logic [LANES*W-1:0]   x2_lanes,
  output logic                 wb_valid,
  output logic [15:0]          wb_ins,
  output logic [LANES*W-1:0]   wb_lanes,
  output logic [LANES-1:0]     wb_mask,
  output logic [W-1:0]         wb_sum,
  output logic                 wb_ovf,
  output logic [7:0]           wb_beats,
  output logic                 err
);

  localparam int unsigned LW = $clog2(LANES);
  // One spare bit keeps the carry slice non-empty even for a single lane.
  localparam int unsigned SW = W + LW + 1;
  localparam logic [3:0]  OP_VDOT = 4'b1110;

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  // C1 pipeline registers
  logic               c1_valid;
  logic [15:0]        c1_ins;
  logic               c1_last;
  logic [LANES-1:0]   c1_mask;
  logic [LANES*W-1:0] c1_lanes;
  logic [W-1:0]       c1_psum;
  logic               c1_carry;

  // C2 accumulation state
  state_t             state;
  logic [W-1:0]       acc;
  logic [15:0]        acc_ins;
  logic               acc_ovf;
  logic [7:0]         cnt;

  logic [SW-1:0]      lane_sum;
  logic               c1_vdot;
  logic               same;
  logic [W:0]         acc_add;
  logic [7:0]         cnt_inc;
  logic               ovf_sum;

  // Full-precision sum of enabled lanes
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (x2_mask[i]) lane_sum = lane_sum + SW'(x2_lanes[i*W +: W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_valid <= 1'b0;
      c1_ins   <= '0;
      c1_last  <= 1'b0;
      c1_mask  <= '0;
      c1_lanes <= '0;
      c1_psum  <= '0;
      c1_carry <= 1'b0;
    end else begin
      c1_valid <= x2_valid;
      c1_ins   <= x2_ins;
      c1_last  <= x2_last;
      c1_mask  <= x2_mask;
      c1_lanes <= x2_lanes;
      c1_psum  <= lane_sum[W-1:0];
      c1_carry <= |lane_sum[SW-1:W];
    end
  end

  assign c1_vdot = (c1_ins[15:12] == OP_VDOT);
  assign same    = (state == ACCUM) && c1_vdot && (c1_ins == acc_ins);
  assign acc_add = {1'b0, acc} + {1'b0, c1_psum};
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign ovf_sum = acc_ovf | c1_carry | acc_add[W];

  // C2: accumulation FSM and registered writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      acc_ins  <= '0;
      acc_ovf  <= 1'b0;
      cnt      <= '0;
      wb_valid <= 1'b0;
      wb_ins   <= '0;
      wb_lanes <= '0;
      wb_mask  <= '0;
      wb_sum   <= '0;
      wb_ovf   <= 1'b0;
      wb_beats <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      if (c1_valid) begin
        // Any beat in ACCUM that does not continue the open vdot aborts it.
        err <= (state == ACCUM) && !same;
        if (!c1_vdot) begin
          state    <= IDLE;
          wb_valid <= 1'b1;
          wb_ins   <= c1_ins;
          wb_lanes <= c1_lanes;
          wb_mask  <= c1_mask;
          wb_sum   <= '0;
          wb_ovf   <= 1'b0;
          wb_beats <= '0;
        end else if (same) begin
          if (c1_last) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_ins   <= c1_ins;
            wb_lanes <= '0;
            wb_mask  <= '0;
            wb_sum   <= acc_add[W-1:0];
            wb_ovf   <= ovf_sum;
            wb_beats <= cnt_inc;
          end else begin
            acc     <= acc_add[W-1:0];
            acc_ovf <= ovf_sum;
            cnt     <= cnt_inc;
          end
        end else if (c1_last) begin
          state    <= IDLE;
          wb_valid <= 1'b1;
          wb_ins   <= c1_ins;
          wb_lanes <= '0;
          wb_mask  <= '0;
          wb_sum   <= c1_psum;
          wb_ovf   <= c1_carry;
          wb_beats <= 8'd1;
        end else begin
          state   <= ACCUM;
          acc     <= c1_psum;
          acc_ins <= c1_ins;
          acc_ovf <= c1_carry;
          cnt     <= 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coalesce.sv
// Randomized and directed check of coalesce against a beat-level reference
// model that tracks each vdot as a true integer total and a beat count.
module tb_coalesce;

  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 16;

  typedef struct {
    logic        valid;
    logic        err;
    logic [15:0] ins;
    logic [63:0] lanes;
    logic [3:0]  mask;
    logic [15:0] sum;
    logic        ovf;
    logic [7:0]  beats;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               x2_valid = 1'b0;
  logic [15:0]        x2_ins = '0;
  logic               x2_last = 1'b0;
  logic [LANES-1:0]   x2_mask = '0;
  logic [LANES*W-1:0] x2_lanes = '0;
  logic               wb_valid;
  logic [15:0]        wb_ins;
  logic [LANES*W-1:0] wb_lanes;
  logic [LANES-1:0]   wb_mask;
  logic [W-1:0]       wb_sum;
  logic               wb_ovf;
  logic [7:0]         wb_beats;
  logic               err;

  coalesce #(.LANES(LANES), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .x2_valid (x2_valid),
    .x2_ins   (x2_ins),
    .x2_last  (x2_last),
    .x2_mask  (x2_mask),
    .x2_lanes (x2_lanes),
    .wb_valid (wb_valid),
    .wb_ins   (wb_ins),
    .wb_lanes (wb_lanes),
    .wb_mask  (wb_mask),
    .wb_sum   (wb_sum),
    .wb_ovf   (wb_ovf),
    .wb_beats (wb_beats),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: an open vdot is just its ins, true total and beat count.
  logic        m_busy = 1'b0;
  logic [15:0] m_ins  = '0;
  longint      m_total = 0;
  int          m_n = 0;

  exp_t exp1, exp2, empty_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] l0, l1, l2, l3;
    l0 = 16'(a); l1 = 16'(b); l2 = 16'(c); l3 = 16'(d);
    return {l3, l2, l1, l0};
  endfunction

  task automatic model(input logic v, input logic [15:0] ins, input logic last,
                       input logic [3:0] mask, input logic [63:0] lanes, output exp_t e);
    longint s;
    logic   vdot;
    e = empty_e;
    if (v) begin
      vdot = (ins[15:12] == 4'hE);
      s = 0;
      for (int i = 0; i < 4; i++) if (mask[i]) s += longint'(lanes[i*16 +: 16]);
      if (m_busy && (!vdot || ins != m_ins)) begin
        e.err  = 1'b1;
        m_busy = 1'b0;
      end
      if (!vdot) begin
        e.valid = 1'b1; e.ins = ins; e.lanes = lanes; e.mask = mask;
      end else begin
        if (!m_busy) begin
          m_busy = 1'b1; m_ins = ins; m_total = 0; m_n = 0;
        end
        m_total += s;
        m_n++;
        if (last) begin
          e.valid = 1'b1;
          e.ins   = ins;
          e.sum   = 16'(m_total % 65536);
          e.ovf   = (m_total >= 65536);
          e.beats = 8'((m_n > 255) ? 255 : m_n);
          m_busy  = 1'b0;
        end
      end
    end
  endtask

  task automatic check_out(input exp_t e);
    check("wb_valid", 64'(wb_valid), 64'(e.valid));
    check("err", 64'(err), 64'(e.err));
    if (e.valid) begin
      check("wb_ins", 64'(wb_ins), 64'(e.ins));
      check("wb_lanes", wb_lanes, e.lanes);
      check("wb_mask", 64'(wb_mask), 64'(e.mask));
      check("wb_sum", 64'(wb_sum), 64'(e.sum));
      check("wb_ovf", 64'(wb_ovf), 64'(e.ovf));
      check("wb_beats", 64'(wb_beats), 64'(e.beats));
    end
  endtask

  // One cycle: check the beat issued two cycles ago, then drive a new one.
  task automatic step(input logic v, input logic [15:0] ins, input logic last,
                      input logic [3:0] mask, input logic [63:0] lanes);
    exp_t e;
    @(negedge clk);
    check_out(exp2);
    exp2 = exp1;
    x2_valid = v; x2_ins = ins; x2_last = last; x2_mask = mask; x2_lanes = lanes;
    model(v, ins, last, mask, lanes, e);
    exp1 = e;
  endtask

  task automatic bubble();
    step(1'b0, 16'h0, 1'b0, 4'h0, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    x2_valid = 1'b0;
    m_busy = 1'b0;
    exp1 = empty_e;
    exp2 = empty_e;
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_wb_ins", 64'(wb_ins), 64'h0);
    check("rst_wb_lanes", wb_lanes, 64'h0);
    check("rst_wb_mask", 64'(wb_mask), 64'h0);
    check("rst_wb_sum", 64'(wb_sum), 64'h0);
    check("rst_wb_ovf", 64'(wb_ovf), 64'h0);
    check("rst_wb_beats", 64'(wb_beats), 64'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_err", 64'(err), 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    empty_e = '{valid: 1'b0, err: 1'b0, ins: '0, lanes: '0, mask: '0,
                sum: '0, ovf: 1'b0, beats: '0};
    exp1 = empty_e;
    exp2 = empty_e;
    do_reset();

    // Single-beat vdot, then pass-through
    step(1'b1, 16'hE003, 1'b1, 4'hF, pack4(1, 2, 3, 4));
    step(1'b1, 16'h8125, 1'b1, 4'h5, pack4(5, 6, 7, 8));
    bubble(); bubble();

    // Three-beat vdot with a bubble after beat 1
    step(1'b1, 16'hE001, 1'b0, 4'hF, pack4(16'h100, 16'h100, 16'h100, 16'h100));
    bubble();
    step(1'b1, 16'hE001, 1'b0, 4'hF, pack4(16'h100, 16'h100, 16'h100, 16'h100));
    step(1'b1, 16'hE001, 1'b1, 4'hF, pack4(16'h100, 16'h100, 16'h100, 16'h100));
    bubble(); bubble();

    // Overflow across two beats
    step(1'b1, 16'hE002, 1'b0, 4'hF, pack4(16'h8000, 16'h8000, 0, 0));
    step(1'b1, 16'hE002, 1'b1, 4'hF, pack4(16'h8000, 16'h8000, 0, 0));
    bubble(); bubble();

    // Abort by a non-vdot beat
    step(1'b1, 16'hE004, 1'b0, 4'hF, pack4(9, 9, 9, 9));
    step(1'b1, 16'h0123, 1'b1, 4'h3, pack4(11, 22, 33, 44));
    bubble(); bubble();

    // Reset in the middle of an accumulation
    step(1'b1, 16'hE005, 1'b0, 4'hF, pack4(7, 7, 7, 7));
    step(1'b1, 16'hE005, 1'b0, 4'hF, pack4(7, 7, 7, 7));
    do_reset();
    step(1'b1, 16'hE005, 1'b1, 4'hF, pack4(2, 2, 2, 2));
    bubble(); bubble();

    // Beat count saturation
    for (int i = 0; i < 300; i++)
      step(1'b1, 16'hE00F, (i == 299), 4'hF, pack4(1, 1, 1, 1));
    bubble(); bubble();

    // Random traffic with deliberate ins collisions between vdots
    for (int i = 0; i < 2000; i++) begin
      logic        v, last;
      logic [15:0] ins;
      logic [3:0]  mask;
      logic [63:0] lanes;
      v = ($urandom_range(0, 3) != 0);
      mask = 4'($urandom);
      for (int j = 0; j < 4; j++)
        lanes[j*16 +: 16] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ins  = 16'hE000 | 16'($urandom_range(0, 1));
        last = ($urandom_range(0, 2) == 0);
      end else begin
        ins = 16'($urandom);
        if (ins[15:12] == 4'hE) ins[15:12] = 4'h1;
        last = 1'b1;
      end
      step(v, ins, last, mask, lanes);
    end
    bubble(); bubble();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coalesce.md
# coalesce

Writeback-side reduction stage placed after the `LANES` parallel two-stage execute lanes. Each cycle it accepts one beat of lane results from the lanes' second execute stage. Non-`vdot` beats pass through unchanged to writeback. `vdot` beats (opcode `4'b1110`, whose lanes emit per-lane products) are summed across lanes and across beats into one scalar, which is written back once on the last beat.

## Interface
- `LANES`, 4: number of execute lanes; power of two, 1..8.
- `W`, 16: datapath width per lane.

- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `x2_valid` input 1: a beat is present this cycle.
- `x2_ins` input 16: instruction of the beat; opcode `[15:12]`, destination `[3:0]`.
- `x2_last` input 1: final beat of the instruction; always 1 for non-`vdot` instructions.
- `x2_mask` input LANES: lane enable; a disabled lane contributes 0.
- `x2_lanes` input LANES*W: lane results; lane i occupies `[i*W +: W]`.
- `wb_valid` output 1: writeback beat valid.
- `wb_ins` output 16: instruction being written back.
- `wb_lanes` output LANES*W: pass-through lane results; all zeros for `vdot`.
- `wb_mask` output LANES: pass-through mask; `{LANES{1'b0}}` for `vdot`.
- `wb_sum` output W: `vdot` result; 0 for other instructions.
- `wb_ovf` output 1: a `vdot` sum carried out of W bits at any point.
- `wb_beats` output 8: number of beats accumulated for this `vdot`; saturates at 255.
- `err` output 1: one-cycle pulse on a protocol violation.

## Operation
- Stage C1 is registered. It computes `psum` = sum over enabled lanes, modulo 2^W, plus a carry flag that is set when the true lane sum reaches 2^W or more. It forwards `valid`, `ins`, `last`, `mask`, `lanes`, `psum` and `carry`.
- Stage C2 holds the FSM (`IDLE`, `ACCUM`) and the output registers.
- All arithmetic is unsigned and modulo 2^W. `wb_ovf` = OR of the C1 carries and the accumulator carry-outs over every beat of the instruction.
- IDLE, non-`vdot` beat: outputs it with `wb_valid`=1, lanes and mask copied, `wb_sum`=0, `wb_ovf`=0, `wb_beats`=0.
- IDLE, `vdot` beat with `last`=1: outputs `wb_sum`=`psum`, `wb_beats`=1. Stays IDLE.
- IDLE, `vdot` beat with `last`=0: `acc`<=`psum`, captures `ins`, sets `cnt`=1, goes to ACCUM. `wb_valid`=0.
- ACCUM, `vdot` beat with the same `ins`: `acc`<=`acc`+`psum` and `cnt`<=`cnt`+1 (saturating).
  - If `last`=1: outputs `acc`+`psum` with count `cnt`+1, then returns to IDLE.
- ACCUM, `vdot` beat with a different `ins`: pulses `err`, discards `acc`, and treats the beat as a fresh IDLE `vdot` beat.
- ACCUM, non-`vdot` beat: pulses `err`, discards `acc`, returns to IDLE and outputs the beat as a normal pass-through. No partial sum is ever written back.
- `x2_valid`=0 in C1 is a bubble: no state change, `wb_valid`=0. A bubble inside ACCUM holds `acc`, `cnt` and state.
- Reset: FSM=IDLE; `acc`, `cnt` and all C1 registers = 0. Outputs: `wb_valid`=0, `wb_ins`=0, `wb_lanes`=0, `wb_mask`=0, `wb_sum`=0, `wb_ovf`=0, `wb_beats`=0, `err`=0. Reset during ACCUM drops the partial sum silently, with no `err`.

## Timing
- Fixed latency of 2 cycles: a beat sampled at edge k reaches C1 at edge k, and its writeback or `err` is visible after edge k+1.
- Throughput is one beat per cycle, with no stall and no backpressure. Pass-through order is preserved.
- `wb_valid` and `err` are high for exactly one cycle per event. They may be high in the same cycle: an abort followed by a pass-through.
- Back-to-back single-beat `vdot`s produce `wb_valid` on consecutive cycles.
- `wb_*` holds its last value when `wb_valid`=0; the testbench ignores it then.

## Test plan
- Reset, then one `vdot` beat: `ins`=0xE003, mask=4'b1111, lanes 1,2,3,4, `last`=1 -> 2 cycles later `wb_valid`=1, `wb_sum`=10, `wb_beats`=1, `wb_ovf`=0.
- Pass-through: `ins`=0x8125, lanes 5,6,7,8, mask=4'b0101 -> 2 cycles later `wb_lanes`=5,6,7,8, `wb_mask`=4'b0101, `wb_sum`=0.
- Three-beat `vdot` with a bubble after beat 1: lanes all 0x0100 each beat, mask 1111 -> a single `wb_valid` 2 cycles after the last beat, `wb_sum`=0x0C00, `wb_beats`=3, no `wb_valid` earlier.
- Overflow: two beats, lanes 0x8000,0x8000,0,0 -> `wb_sum`=0, `wb_ovf`=1.
- Abort: `vdot` beat with `last`=0, then an ADD beat (`ins`=0x0123) -> `err` pulses and the ADD is written back in the same cycle; no `vdot` writeback.
- Assert `rst` mid-ACCUM, release, then a single-beat `vdot` with lanes 2,2,2,2 -> `wb_sum`=8, `wb_beats`=1, and `err` stays 0 throughout.
